// File: rtl/sw_input_port.sv
// Switch input peripheral: synchronises and debounces the board switches, keeps
// sticky edge flags and a flip counter, and answers LSU loads/stores in its window.
module sw_input_port #(
  parameter int unsigned          SW_W      = 8,
  parameter int unsigned          ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(10'h240),
  parameter int unsigned          DB_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SW_W-1:0]   io_sw,
  input  logic              bus_re_i,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [31:0]       bus_wd_i,
  output logic [31:0]       bus_rd_o,
  output logic              bus_rvalid_o,
  output logic [SW_W-1:0]   sw_db_o
);

  localparam int unsigned       CNT_W     = $clog2(DB_CYCLES);
  localparam int unsigned       WIN_BYTES = 64;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DB_CYCLES - 1);
  localparam logic [3:0]        REG_RAW   = 4'd0;
  localparam logic [3:0]        REG_DB    = 4'd1;
  localparam logic [3:0]        REG_EDGE  = 4'd2;
  localparam logic [3:0]        REG_TCNT  = 4'd3;

  logic [SW_W-1:0]   sync1_q, sync2_q;
  logic [SW_W-1:0]   db_q, db_d;
  logic [SW_W-1:0]   edge_q, edge_d;
  logic [SW_W-1:0]   flip;
  logic [CNT_W-1:0]  cnt_q [SW_W];
  logic [CNT_W-1:0]  cnt_d [SW_W];
  logic [15:0]       tcnt_q, tcnt_d;
  logic [31:0]       rd_q, rd_d;
  logic              rvalid_q, rvalid_d;

  logic [ADDR_W-1:0] offset;
  logic              in_win;
  logic [3:0]        word_sel;
  logic              rd_hit, wr_hit;
  logic              wr_edge, wr_tcnt;
  logic [31:0]       reg_rdata;
  logic [16:0]       flip_sum;
  logic [16:0]       tcnt_sum;
  logic              unused_bits;

  // Address decode: byte offset into the 64-byte window, word-granular select.
  always_comb begin
    offset   = bus_addr_i - BASE_ADDR;
    in_win   = (bus_addr_i >= BASE_ADDR) && (offset < ADDR_W'(WIN_BYTES));
    word_sel = offset[5:2];
    rd_hit   = bus_re_i && in_win;
    wr_hit   = bus_we_i && in_win;
    wr_edge  = wr_hit && (word_sel == REG_EDGE);
    wr_tcnt  = wr_hit && (word_sel == REG_TCNT);
  end

  assign unused_bits = ^{bus_wd_i, offset};

  // Per-bit debounce: a level must differ for DB_CYCLES consecutive cycles to be accepted.
  always_comb begin
    flip = '0;
    for (int i = 0; i < int'(SW_W); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          flip[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    db_d = db_q ^ flip;
  end

  always_comb begin
    flip_sum = '0;
    for (int i = 0; i < int'(SW_W); i++) begin
      flip_sum = flip_sum + 17'(flip[i]);
    end
  end

  // Sticky edges (set beats W1C) and saturating flip counter (store reloads with this cycle's flips).
  always_comb begin
    edge_d   = (edge_q & ~(wr_edge ? bus_wd_i[SW_W-1:0] : '0)) | flip;
    tcnt_sum = {1'b0, tcnt_q} + flip_sum;
    if (wr_tcnt) begin
      tcnt_d = 16'(flip_sum);
    end else if (tcnt_sum[16]) begin
      tcnt_d = 16'hFFFF;
    end else begin
      tcnt_d = tcnt_sum[15:0];
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (word_sel)
      REG_RAW:  reg_rdata = 32'(sync2_q);
      REG_DB:   reg_rdata = 32'(db_q);
      REG_EDGE: reg_rdata = 32'(edge_q);
      REG_TCNT: reg_rdata = {16'h0000, tcnt_q};
      default:  reg_rdata = '0;
    endcase
    rd_d     = rd_hit ? reg_rdata : '0;
    rvalid_d = rd_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      edge_q   <= '0;
      tcnt_q   <= '0;
      rd_q     <= '0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < int'(SW_W); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= io_sw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      edge_q   <= edge_d;
      tcnt_q   <= tcnt_d;
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < int'(SW_W); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus_rd_o     = rd_q;
  assign bus_rvalid_o = rvalid_q;
  assign sw_db_o      = db_q;

endmodule

// File: tb/tb_sw_input_port.sv
// Directed bench for sw_input_port: a default instance for timing/register behaviour
// and a short-debounce instance used to reach the flip-counter saturation point.
module tb_sw_input_port;

  logic        clk_i = 1'b0;
  logic        rst_i;

  logic [7:0]  io_sw;
  logic        bus_re_i, bus_we_i;
  logic [9:0]  bus_addr_i;
  logic [31:0] bus_wd_i;
  logic [31:0] bus_rd_o;
  logic        bus_rvalid_o;
  logic [7:0]  sw_db_o;

  logic [7:0]  s_io_sw;
  logic        s_re, s_we;
  logic [9:0]  s_addr;
  logic [31:0] s_wd;
  logic [31:0] s_rd;
  logic        s_rvalid;
  logic [7:0]  s_db;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  sw_input_port u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .io_sw        (io_sw),
    .bus_re_i     (bus_re_i),
    .bus_we_i     (bus_we_i),
    .bus_addr_i   (bus_addr_i),
    .bus_wd_i     (bus_wd_i),
    .bus_rd_o     (bus_rd_o),
    .bus_rvalid_o (bus_rvalid_o),
    .sw_db_o      (sw_db_o)
  );

  sw_input_port #(.DB_CYCLES(2)) u_sat (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .io_sw        (s_io_sw),
    .bus_re_i     (s_re),
    .bus_we_i     (s_we),
    .bus_addr_i   (s_addr),
    .bus_wd_i     (s_wd),
    .bus_rd_o     (s_rd),
    .bus_rvalid_o (s_rvalid),
    .sw_db_o      (s_db)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_rd(input string tag, input logic [9:0] addr,
                        input logic [31:0] exp_d, input logic exp_v);
    bus_re_i   = 1'b1;
    bus_addr_i = addr;
    tick();
    bus_re_i   = 1'b0;
    chk({tag, ".rd"}, bus_rd_o, exp_d);
    chk({tag, ".rv"}, 32'(bus_rvalid_o), 32'(exp_v));
  endtask

  task automatic bus_wr(input logic [9:0] addr, input logic [31:0] wd);
    bus_we_i   = 1'b1;
    bus_addr_i = addr;
    bus_wd_i   = wd;
    tick();
    bus_we_i   = 1'b0;
  endtask

  task automatic sat_rd(input string tag, input logic [9:0] addr, input logic [31:0] exp_d);
    s_re   = 1'b1;
    s_addr = addr;
    tick();
    s_re   = 1'b0;
    chk({tag, ".rd"}, s_rd, exp_d);
    chk({tag, ".rv"}, 32'(s_rvalid), 32'h1);
  endtask

  initial begin
    rst_i      = 1'b1;
    io_sw      = 8'h00;
    bus_re_i   = 1'b0;
    bus_we_i   = 1'b0;
    bus_addr_i = '0;
    bus_wd_i   = '0;
    s_io_sw    = 8'h00;
    s_re       = 1'b0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_wd       = '0;

    // Reset state
    #23;
    chk("rst.db", 32'(sw_db_o), 32'h0);
    chk("rst.rv", 32'(bus_rvalid_o), 32'h0);
    chk("rst.rd", bus_rd_o, 32'h0);
    rst_i = 1'b0;
    tick();
    bus_rd("rst.tcnt", 10'h24C, 32'h0, 1'b1);

    // Clean step: 2 sync + 16 debounce cycles
    io_sw = 8'hA5;
    ticks(17);
    chk("step.db17", 32'(sw_db_o), 32'h00);
    tick();
    chk("step.db18", 32'(sw_db_o), 32'hA5);
    bus_rd("step.raw",  10'h240, 32'hA5, 1'b1);
    bus_rd("step.sdb",  10'h244, 32'hA5, 1'b1);
    bus_rd("step.edge", 10'h248, 32'hA5, 1'b1);
    bus_rd("step.tcnt", 10'h24C, 32'h4,  1'b1);
    bus_rd("step.hole", 10'h250, 32'h0,  1'b1);

    // Glitch of DB_CYCLES-2 cycles on bit 0 is rejected
    io_sw = 8'hA4;
    ticks(14);
    io_sw = 8'hA5;
    ticks(20);
    chk("glitch.db", 32'(sw_db_o), 32'hA5);
    bus_rd("glitch.edge", 10'h248, 32'hA5, 1'b1);
    bus_rd("glitch.tcnt", 10'h24C, 32'h4,  1'b1);

    // Load then idle, W1C on EDGE
    bus_rd("w1c.pre", 10'h248, 32'hA5, 1'b1);
    tick();
    chk("idle.rv", 32'(bus_rvalid_o), 32'h0);
    chk("idle.rd", bus_rd_o, 32'h0);
    bus_wr(10'h248, 32'h05);
    bus_rd("w1c.post", 10'h248, 32'hA0, 1'b1);

    // Flip on bit 7 coincides with W1C of bit 7: set wins
    bus_wr(10'h248, 32'h80);
    bus_rd("w1c.b7", 10'h248, 32'h20, 1'b1);
    io_sw = 8'h25;
    ticks(17);
    chk("race.dbpre", 32'(sw_db_o), 32'hA5);
    bus_wr(10'h248, 32'h80);
    chk("race.db", 32'(sw_db_o), 32'h25);
    bus_rd("race.edge", 10'h248, 32'hA0, 1'b1);

    // Same-cycle load and store to TCNT returns the pre-write value
    bus_re_i   = 1'b1;
    bus_we_i   = 1'b1;
    bus_addr_i = 10'h24C;
    bus_wd_i   = 32'h1234;
    tick();
    bus_re_i   = 1'b0;
    bus_we_i   = 1'b0;
    chk("rw.rd", bus_rd_o, 32'h5);
    chk("rw.rv", 32'(bus_rvalid_o), 32'h1);
    bus_rd("rw.tcnt", 10'h24C, 32'h0, 1'b1);

    // Outside the window: stores ignored, loads unanswered
    bus_wr(10'h288, 32'hFF);
    bus_rd("oow.edge", 10'h248, 32'hA0, 1'b1);
    bus_rd("oow.hi",   10'h280, 32'h0,  1'b0);
    bus_rd("oow.lo",   10'h23C, 32'h0,  1'b0);

    // Asynchronous reset mid-debounce with a load response outstanding
    io_sw = 8'h00;
    ticks(10);
    chk("arst.dbpre", 32'(sw_db_o), 32'h25);
    bus_rd("arst.rdpre", 10'h244, 32'h25, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst.db", 32'(sw_db_o), 32'h0);
    chk("arst.rv", 32'(bus_rvalid_o), 32'h0);
    chk("arst.rd", bus_rd_o, 32'h0);
    #2 rst_i = 1'b0;
    tick();
    bus_rd("arst.edge", 10'h248, 32'h0, 1'b1);
    bus_rd("arst.tcnt", 10'h24C, 32'h0, 1'b1);
    bus_rd("arst.sdb",  10'h244, 32'h0, 1'b1);

    // Saturation on the short-debounce instance: 8191*8 + 6 = 0xFFFE flips
    for (int i = 0; i < 8191; i++) begin
      s_io_sw = ~s_io_sw;
      ticks(5);
    end
    s_io_sw = s_io_sw ^ 8'h3F;
    ticks(5);
    chk("sat.db", 32'(s_db), 32'hC0);
    sat_rd("sat.fffe", 10'h24C, 32'hFFFE);
    s_io_sw = s_io_sw ^ 8'h07;
    ticks(5);
    sat_rd("sat.ffff", 10'h24C, 32'hFFFF);
    s_io_sw = s_io_sw ^ 8'h07;
    ticks(5);
    sat_rd("sat.hold", 10'h24C, 32'hFFFF);

    // Store to TCNT in the same cycle as two flips
    s_io_sw = s_io_sw ^ 8'h03;
    ticks(3);
    s_we   = 1'b1;
    s_addr = 10'h24C;
    s_wd   = 32'h0;
    tick();
    s_we   = 1'b0;
    chk("tclr.db", 32'(s_db), 32'hC3);
    sat_rd("tclr.tcnt", 10'h24C, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
